// File: rtl/booth_mult_r4.sv
// booth_mult_r4: sequential radix-4 (modified) Booth multiplier.
// Retires two multiplier bits per cycle. Each operation can be signed or unsigned.
// Valid/ready handshake on the operand side and on the product side.
module booth_mult_r4 #(
    parameter int unsigned MUL_A_W   = 16,
    parameter int unsigned MUL_B_W   = 16,
    parameter int unsigned MUL_OUT_W = MUL_A_W + MUL_B_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 in_signed_i,
    input  logic [MUL_A_W-1:0]   in_A_i,
    input  logic [MUL_B_W-1:0]   in_B_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [MUL_OUT_W-1:0] mult_out_o,
    output logic                 busy_o
);

    // Extended multiplier width: smallest even number >= MUL_A_W+1.
    localparam int unsigned EW    = (MUL_A_W % 2 == 1) ? MUL_A_W + 1 : MUL_A_W + 2;
    localparam int unsigned N     = EW / 2;
    // The accumulator is wide enough to hold +/-2B.
    localparam int unsigned BW    = MUL_B_W + 2;
    // One guard bit on the pre-shift sum keeps |acc| + |2B| exact.
    localparam int unsigned SW    = BW + 1;
    localparam int unsigned CNT_W = $clog2(N + 1);

    // Reject an inconsistent configuration at elaboration.
    if (MUL_OUT_W != MUL_A_W + MUL_B_W) begin : g_bad_out_w
        $error("booth_mult_r4: MUL_OUT_W must equal MUL_A_W + MUL_B_W");
    end
    if (MUL_A_W < 2 || MUL_B_W < 2) begin : g_bad_in_w
        $error("booth_mult_r4: operand widths must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [BW-1:0]      acc;
    logic [EW-1:0]      mreg;
    logic               mprev;
    logic [BW-1:0]      mcand;
    logic [CNT_W-1:0]   cnt;

    logic               accept;
    logic               last_step;
    logic [2:0]         triplet;
    logic [SW-1:0]      b_sx;
    logic [SW-1:0]      sel;
    logic [SW-1:0]      sum;
    logic [BW-1:0]      acc_step;
    logic [EW-1:0]      mreg_step;
    logic [EW-1:0]      a_ext;
    logic [BW-1:0]      b_ext;

    // Operand-side readiness. This is the only combinational input-to-output path.
    always_comb begin
        in_ready_o = (state == IDLE) || ((state == DONE) && out_ready_i);
        accept     = in_valid_i && in_ready_o;
        last_step  = (state == CALC) && (cnt == CNT_W'(1));
    end

    // Sign- or zero-extend the operands according to the requested mode.
    always_comb begin
        a_ext = {{(EW - MUL_A_W){in_signed_i & in_A_i[MUL_A_W-1]}}, in_A_i};
        b_ext = {{(BW - MUL_B_W){in_signed_i & in_B_i[MUL_B_W-1]}}, in_B_i};
    end

    // Booth digit selection, accumulation and the 2-bit arithmetic shift.
    always_comb begin
        triplet = {mreg[1], mreg[0], mprev};
        b_sx    = {mcand[BW-1], mcand};
        sel     = '0;
        case (triplet)
            3'b001, 3'b010: sel = b_sx;
            3'b011:         sel = {mcand, 1'b0};
            3'b100:         sel = SW'(0) - {mcand, 1'b0};
            3'b101, 3'b110: sel = SW'(0) - b_sx;
            default:        sel = '0;
        endcase
        sum       = {acc[BW-1], acc} + sel;
        acc_step  = {sum[SW-1], sum[SW-1:2]};
        mreg_step = {sum[1:0], mreg[EW-1:2]};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_next = in_valid_i ? CALC : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture and iteration datapath. The product is loaded on the final step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            mreg       <= '0;
            mprev      <= 1'b0;
            mcand      <= '0;
            cnt        <= '0;
            mult_out_o <= '0;
        end else if (accept) begin
            acc   <= '0;
            mreg  <= a_ext;
            mprev <= 1'b0;
            mcand <= b_ext;
            cnt   <= CNT_W'(N);
        end else if (state == CALC) begin
            acc   <= acc_step;
            mreg  <= mreg_step;
            mprev <= mreg[1];
            cnt   <= cnt - CNT_W'(1);
            if (last_step) begin
                mult_out_o <= MUL_OUT_W'({acc_step, mreg_step});
            end
        end
    end

    // Registered status outputs follow the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            out_valid_o <= (state_next == DONE);
            busy_o      <= (state_next == CALC);
        end
    end

endmodule
